sensor_snapshot_regs: RTL and testbench

Parametrised, byte-addressed sensor register bank for NUM_CH sensor channels of CH_WIDTH bits each. Live registers capture each channel on its own valid strobe. A single-cycle snapshot copies all channels atomically into a read bank, so a multi-byte read sequence is always coherent. Per-channel fresh flags, an overrun flag, a snapshot sequence counter and a registered read port with a valid/error handshake sit between the sensor front-ends and the telemetry/bus readout logic.

---
 rtl/sensor_regmap_pkg.sv | 13 +
 rtl/sensor_chan_slot.sv | 43 ++++
 rtl/sensor_snapshot_regs.sv | 109 ++++++++++
 tb/tb_sensor_snapshot_regs.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sensor_regmap_pkg.sv
// sensor_regmap_pkg: register map constants and layout helpers for the sensor snapshot bank
package sensor_regmap_pkg;
    localparam int ADDR_ID    = 0;
    localparam int ADDR_SEQ   = 1;
    localparam int ADDR_STAT  = 2;
    localparam int ADDR_FRESH = 3;
    localparam logic [7:0] ID_VAL_DEFAULT = 8'hA5;

    // First snapshot data address: fixed registers plus one fresh byte per 8 channels
    function automatic int calc_base(input int num_ch);
        return ADDR_FRESH + (num_ch + 7) / 8;
    endfunction
endpackage

// File: rtl/sensor_chan_slot.sv
// sensor_chan_slot: live/snapshot storage and freshness tracking for one sensor channel
module sensor_chan_slot #(
    parameter int CH_WIDTH = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_WIDTH-1:0] data_i,
    input  logic                valid_i,
    input  logic                snap_i,
    output logic [CH_WIDTH-1:0] snap_o,
    output logic                fresh_o,
    output logic                ovr_o
);
    logic [CH_WIDTH-1:0] live_q, live_d, snap_q, snap_d;
    logic                fresh_live_q, fresh_live_d, fresh_snap_q, fresh_snap_d;

    // A new sample keeps the channel fresh even when a snapshot takes the old value
    always_comb begin
        live_d       = valid_i ? data_i : live_q;
        snap_d       = snap_i ? live_q : snap_q;
        fresh_live_d = valid_i | (fresh_live_q & ~snap_i);
        fresh_snap_d = snap_i ? fresh_live_q : fresh_snap_q;
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q       <= '0;
            snap_q       <= '0;
            fresh_live_q <= 1'b0;
            fresh_snap_q <= 1'b0;
        end else begin
            live_q       <= live_d;
            snap_q       <= snap_d;
            fresh_live_q <= fresh_live_d;
            fresh_snap_q <= fresh_snap_d;
        end
    end

    assign snap_o  = snap_q;
    assign fresh_o = fresh_snap_q;
    assign ovr_o   = valid_i & fresh_live_q;
endmodule

// File: rtl/sensor_snapshot_regs.sv
// sensor_snapshot_regs: byte-addressed register bank with atomic multi-channel snapshot
module sensor_snapshot_regs
    import sensor_regmap_pkg::*;
#(
    parameter int         NUM_CH   = 12,
    parameter int         CH_WIDTH = 24,
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] ID_VAL   = ID_VAL_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]          ch_valid_i,
    input  logic                       snap_req_i,
    input  logic                       rd_en_i,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    output logic [7:0]                 rd_data_o,
    output logic                       rd_valid_o,
    output logic                       rd_err_o,
    output logic [7:0]                 seq_o
);
    localparam int BPC  = CH_WIDTH / 8;
    localparam int FB   = (NUM_CH + 7) / 8;
    localparam int BASE = calc_base(NUM_CH);

    if (CH_WIDTH % 8 != 0 || BASE + NUM_CH * BPC > 2 ** ADDR_W) begin : g_bad_cfg
        $error("sensor_snapshot_regs: channel layout does not fit the address space");
    end

    logic [NUM_CH*CH_WIDTH-1:0] snap_flat;
    logic [NUM_CH-1:0]          fresh_snap, ovr_hit;
    logic [FB*8-1:0]            fresh_pad;
    logic [7:0]                 seq_q, seq_d, rd_data_q, rd_data_d, rd_byte;
    logic                       ovr_q, ovr_d, rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic                       hit, stat_rd;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        sensor_chan_slot #(.CH_WIDTH(CH_WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .data_i  (ch_data_i[k*CH_WIDTH +: CH_WIDTH]),
            .valid_i (ch_valid_i[k]),
            .snap_i  (snap_req_i),
            .snap_o  (snap_flat[k*CH_WIDTH +: CH_WIDTH]),
            .fresh_o (fresh_snap[k]),
            .ovr_o   (ovr_hit[k])
        );
    end

    assign fresh_pad = (FB*8)'(fresh_snap);

    // Address decode: fixed registers, fresh bitmap bytes, then snapshot bytes MSB first
    always_comb begin
        rd_byte = 8'h00;
        hit     = 1'b1;
        if (rd_addr_i == ADDR_W'(ADDR_ID))
            rd_byte = ID_VAL;
        else if (rd_addr_i == ADDR_W'(ADDR_SEQ))
            rd_byte = seq_q;
        else if (rd_addr_i == ADDR_W'(ADDR_STAT))
            rd_byte = {7'b0, ovr_q};
        else begin
            hit = 1'b0;
            for (int i = 0; i < FB; i++)
                if (rd_addr_i == ADDR_W'(ADDR_FRESH + i)) begin
                    rd_byte = fresh_pad[i*8 +: 8];
                    hit     = 1'b1;
                end
            for (int c = 0; c < NUM_CH; c++)
                for (int b = 0; b < BPC; b++)
                    if (rd_addr_i == ADDR_W'(BASE + c * BPC + b)) begin
                        rd_byte = snap_flat[c*CH_WIDTH + CH_WIDTH - 8 - 8*b +: 8];
                        hit     = 1'b1;
                    end
        end
    end

    // Overrun set beats the clearing read; reads see pre-update seq and bank
    always_comb begin
        stat_rd    = rd_en_i && rd_addr_i == ADDR_W'(ADDR_STAT);
        seq_d      = seq_q + {7'b0, snap_req_i};
        ovr_d      = (|ovr_hit) | (ovr_q & ~stat_rd);
        rd_data_d  = rd_en_i ? rd_byte : rd_data_q;
        rd_valid_d = rd_en_i;
        rd_err_d   = rd_en_i & ~hit;
    end

    // Status and read-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q      <= 8'h00;
            ovr_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            ovr_q      <= ovr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign seq_o      = seq_q;
endmodule

// File: tb/tb_sensor_snapshot_regs.sv
// tb_sensor_snapshot_regs: directed table, random traffic against a register-map model, reset corners
module tb_sensor_snapshot_regs;
    localparam int NUM_CH = 12, CH_WIDTH = 24, BPC = 3, FB = 2, BASE = 5;

    logic                       clk = 1'b0, rst = 1'b1;
    logic [NUM_CH*CH_WIDTH-1:0] ch_data = '0;
    logic [NUM_CH-1:0]          ch_valid = '0;
    logic                       snap_req = 1'b0, rd_en = 1'b0;
    logic [7:0]                 rd_addr = '0, rd_data, seq;
    logic                       rd_valid, rd_err;

    sensor_snapshot_regs dut (
        .clk(clk), .rst(rst), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
        .snap_req_i(snap_req), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_err_o(rd_err), .seq_o(seq)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    logic [23:0] m_live[NUM_CH], m_snap[NUM_CH];
    bit          m_fl[NUM_CH], m_fs[NUM_CH];
    bit          m_ovr, m_valid, m_err;
    int          m_seq;
    logic [7:0]  m_rd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_live[i] = '0; m_snap[i] = '0; m_fl[i] = 0; m_fs[i] = 0;
        end
        m_ovr = 0; m_seq = 0; m_rd = 8'h00; m_valid = 0; m_err = 0;
    endtask

    task automatic model_read(input int a, output logic [7:0] d, output bit e);
        d = 8'h00; e = 0;
        if (a == 0) d = 8'hA5;
        else if (a == 1) d = 8'(m_seq);
        else if (a == 2) d = {7'b0, m_ovr};
        else if (a < BASE) begin
            for (int j = 0; j < 8; j++)
                if ((a - 3) * 8 + j < NUM_CH) d[j] = m_fs[(a - 3) * 8 + j];
        end else if (a < BASE + NUM_CH * BPC)
            d = 8'(m_snap[(a - BASE) / BPC] >> (8 * (BPC - 1 - (a - BASE) % BPC)));
        else e = 1;
    endtask

    task automatic model_update(input logic [NUM_CH-1:0] v, input logic [NUM_CH*CH_WIDTH-1:0] d,
                                input bit s, input bit r, input int a);
        bit ov = 0;
        for (int i = 0; i < NUM_CH; i++) if (v[i] && m_fl[i]) ov = 1;
        if (r && a == 2) m_ovr = 0;
        if (ov) m_ovr = 1;
        if (s) begin
            for (int i = 0; i < NUM_CH; i++) begin m_snap[i] = m_live[i]; m_fs[i] = m_fl[i]; m_fl[i] = 0; end
            m_seq = (m_seq + 1) % 256;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (v[i]) begin m_live[i] = d[i*CH_WIDTH +: CH_WIDTH]; m_fl[i] = 1; end
    endtask

    task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH*CH_WIDTH-1:0] d,
                        input bit s, input bit r, input logic [7:0] a);
        @(negedge clk);
        ch_valid = v; ch_data = d; snap_req = s; rd_en = r; rd_addr = a;
        m_valid = r; m_err = 0;
        if (r) model_read(int'(a), m_rd, m_err);
        model_update(v, d, s, r, int'(a));
        @(posedge clk); #1;
        check("rd_port{valid,err,data}", {22'b0, rd_valid, rd_err, rd_data}, {22'b0, m_valid, m_err, m_rd});
        check("seq", {24'b0, seq}, 32'(m_seq));
    endtask

    typedef struct {
        int          ch;
        logic [23:0] d;
        bit          s;
        bit          r;
        logic [7:0]  a;
        logic [7:0]  ed;
        bit          ee;
    } vec_t;

    vec_t tbl[$];
    logic [NUM_CH-1:0]          v;
    logic [NUM_CH*CH_WIDTH-1:0] d;

    initial begin
        tbl = '{
            '{-1, 24'h0, 0, 1, 8'h00, 8'hA5, 0},
            '{-1, 24'h0, 0, 1, 8'h01, 8'h00, 0},
            '{-1, 24'h0, 0, 1, 8'h02, 8'h00, 0},
            '{ 0, 24'h123456, 0, 0, 8'h00, 8'h00, 0},
            '{-1, 24'h0, 1, 0, 8'h00, 8'h00, 0},
            '{-1, 24'h0, 0, 1, 8'h05, 8'h12, 0},
            '{-1, 24'h0, 0, 1, 8'h06, 8'h34, 0},
            '{-1, 24'h0, 0, 1, 8'h07, 8'h56, 0},
            '{-1, 24'h0, 0, 1, 8'h03, 8'h01, 0},
            '{-1, 24'h0, 0, 1, 8'h01, 8'h01, 0},
            '{ 0, 24'hABCDEF, 0, 0, 8'h00, 8'h01, 0},
            '{-1, 24'h0, 0, 1, 8'h05, 8'h12, 0},
            '{-1, 24'h0, 0, 1, 8'h06, 8'h34, 0},
            '{-1, 24'h0, 0, 1, 8'h07, 8'h56, 0},
            '{-1, 24'h0, 1, 0, 8'h00, 8'h56, 0},
            '{-1, 24'h0, 0, 1, 8'h05, 8'hAB, 0},
            '{-1, 24'h0, 0, 1, 8'h06, 8'hCD, 0},
            '{-1, 24'h0, 0, 1, 8'h07, 8'hEF, 0},
            '{-1, 24'h0, 0, 1, 8'h01, 8'h02, 0},
            '{ 3, 24'h000111, 0, 0, 8'h00, 8'h02, 0},
            '{ 3, 24'h000222, 0, 0, 8'h00, 8'h02, 0},
            '{-1, 24'h0, 0, 1, 8'h02, 8'h01, 0},
            '{-1, 24'h0, 0, 1, 8'h02, 8'h00, 0},
            '{ 3, 24'h000333, 0, 0, 8'h00, 8'h00, 0},
            '{ 3, 24'h000444, 0, 1, 8'h02, 8'h01, 0},
            '{-1, 24'h0, 0, 1, 8'h02, 8'h01, 0},
            '{-1, 24'h0, 0, 1, 8'h02, 8'h00, 0},
            '{ 1, 24'h000001, 1, 1, 8'h01, 8'h02, 0},
            '{-1, 24'h0, 0, 1, 8'h03, 8'h08, 0},
            '{-1, 24'h0, 0, 1, 8'h0A, 8'h00, 0},
            '{-1, 24'h0, 1, 0, 8'h00, 8'h00, 0},
            '{-1, 24'h0, 0, 1, 8'h03, 8'h02, 0},
            '{-1, 24'h0, 0, 1, 8'h0A, 8'h01, 0},
            '{-1, 24'h0, 0, 1, 8'h29, 8'h00, 1},
            '{-1, 24'h0, 0, 1, 8'hFF, 8'h00, 1},
            '{-1, 24'h0, 0, 1, 8'h00, 8'hA5, 0},
            '{-1, 24'h0, 0, 0, 8'h07, 8'hA5, 0}
        };
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset rd_data", {24'b0, rd_data}, 32'h00);
        check("reset seq", {24'b0, seq}, 32'h00);
        @(negedge clk) rst = 1'b0;

        foreach (tbl[n]) begin
            v = '0; d = '0;
            if (tbl[n].ch >= 0) begin
                v[tbl[n].ch] = 1'b1;
                d[tbl[n].ch*CH_WIDTH +: CH_WIDTH] = tbl[n].d;
            end
            step(v, d, tbl[n].s, tbl[n].r, tbl[n].a);
            check($sformatf("table[%0d] rd_data", n), {24'b0, rd_data}, {24'b0, tbl[n].ed});
            check($sformatf("table[%0d] rd_err", n), {31'b0, rd_err}, {31'b0, tbl[n].ee});
            check($sformatf("table[%0d] rd_valid", n), {31'b0, rd_valid}, {31'b0, tbl[n].r});
        end

        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                v[i] = ($urandom_range(0, 4) == 0);
                d[i*CH_WIDTH +: CH_WIDTH] = 24'($urandom);
            end
            step(v, d, $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 42)));
        end

        @(negedge clk);
        ch_valid = '0; snap_req = 1'b0; rd_en = 1'b1; rd_addr = 8'h00;
        @(posedge clk); #1;
        check("pre-reset rd_valid", {31'b0, rd_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async reset drops rd_valid", {31'b0, rd_valid}, 32'd0);
        check("async reset rd_data", {24'b0, rd_data}, 32'h00);
        @(negedge clk) rst = 1'b0;
        rd_en = 1'b1; rd_addr = 8'h01;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("reset during pending read", {31'b0, rd_valid}, 32'd0);
        check("reset during pending seq", {24'b0, seq}, 32'h00);
        @(negedge clk) rst = 1'b0; rd_en = 1'b0;
        model_reset();
        step('0, '0, 0, 1, 8'h02);
        step('0, '0, 0, 1, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
